// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product stream in, saturated frame sum out, plus frame abort.
interface product_accumulator_if #(parameter int PROD_W = 8, parameter int ACC_W = 12);
  logic in_valid;
  logic in_ready;
  logic [PROD_W-1:0] in_product;
  logic clear;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  logic out_ovf;
  modport master(output in_valid, in_product, clear, out_ready, input in_ready, out_valid, out_sum, out_ovf);
  modport slave(input in_valid, in_product, clear, out_ready, output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN signed products per frame with saturation and a sticky overflow flag.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W = 12,
  parameter int LEN = 4
) (
  input logic clk,
  input logic rst_n,
  product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic signed [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0] LAST = 8'(LEN - 1);
  state_t state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [7:0] cnt, cnt_n;
  logic ovf, ovf_n, ov, ov_n;
  logic [ACC_W:0] sum;
  logic fire, sat;
  assign bus.in_ready = (state != HOLD) && !bus.clear;
  assign bus.out_valid = ov;
  assign bus.out_sum = acc;
  assign bus.out_ovf = ovf;
  assign fire = bus.in_valid && bus.in_ready;
  // one guard bit: overflow shows up as the top two bits disagreeing
  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product};
  assign sat = sum[ACC_W] != sum[ACC_W-1];
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf;
    ov_n = ov;
    if (bus.clear || (ov && bus.out_ready)) begin
      state_n = IDLE;
      acc_n = '0;
      cnt_n = '0;
      ovf_n = 1'b0;
      ov_n = 1'b0;
    end else if (fire) begin
      acc_n = sat ? (sum[ACC_W] ? MIN : MAX) : sum[ACC_W-1:0];
      ovf_n = ovf | sat;
      cnt_n = cnt + 8'd1;
      state_n = (cnt == LAST) ? HOLD : ACCUM;
      ov_n = cnt == LAST;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      ov <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      ov <= ov_n;
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed frames on LEN=4, LEN=20 and LEN=1 instances, scoreboard-checked results.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) a();
  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) b();
  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) c();
  product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(4)) dut_a(.clk(clk), .rst_n(rst_n), .bus(a.slave));
  product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(20)) dut_b(.clk(clk), .rst_n(rst_n), .bus(b.slave));
  product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(1)) dut_c(.clk(clk), .rst_n(rst_n), .bus(c.slave));

  int passed = 0;
  int total = 0;
  logic [12:0] qa[$];
  logic [12:0] qb[$];
  logic [12:0] qc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // result monitors: a handshake with clear high discards the result
  always @(negedge clk)
    if (rst_n && a.out_valid && a.out_ready && !a.clear) begin
      if (qa.size() == 0) begin total++; $display("FAIL a_unexpected: got result %0h expected none", {a.out_ovf, a.out_sum}); end
      else check("a_result", {19'd0, a.out_ovf, a.out_sum}, {19'd0, qa.pop_front()});
    end
  always @(negedge clk)
    if (rst_n && b.out_valid && b.out_ready && !b.clear) begin
      if (qb.size() == 0) begin total++; $display("FAIL b_unexpected: got result %0h expected none", {b.out_ovf, b.out_sum}); end
      else check("b_result", {19'd0, b.out_ovf, b.out_sum}, {19'd0, qb.pop_front()});
    end
  always @(negedge clk)
    if (rst_n && c.out_valid && c.out_ready && !c.clear) begin
      if (qc.size() == 0) begin total++; $display("FAIL c_unexpected: got result %0h expected none", {c.out_ovf, c.out_sum}); end
      else check("c_result", {19'd0, c.out_ovf, c.out_sum}, {19'd0, qc.pop_front()});
    end

  task automatic drive(input int d, input logic v, input logic [7:0] p);
    if (d == 0) begin a.in_valid = v; a.in_product = p; end
    else if (d == 1) begin b.in_valid = v; b.in_product = p; end
    else begin c.in_valid = v; c.in_product = p; end
  endtask

  function automatic logic rdy(input int d);
    return d == 0 ? a.in_ready : d == 1 ? b.in_ready : c.in_ready;
  endfunction

  // offer p and return #1 after the edge that accepted it, in_valid left high
  task automatic send(input int d, input logic [7:0] p);
    int n = 0;
    drive(d, 1'b1, p);
    @(negedge clk);
    while (!rdy(d) && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin total++; $display("FAIL send_timeout: dut %0d product %0h got no in_ready expected accept", d, p); end
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 expected finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 8'd0); drive(1, 1'b0, 8'd0); drive(2, 1'b0, 8'd0);
    a.clear = 1'b0; b.clear = 1'b0; c.clear = 1'b0;
    a.out_ready = 1'b1; b.out_ready = 1'b1; c.out_ready = 1'b1;
    #12;
    check("rst_valid", a.out_valid, 0);
    check("rst_sum", a.out_sum, 0);
    check("rst_ovf", a.out_ovf, 0);
    check("rst_in_ready", a.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    // basic frame 10, -3, 7, -20 -> -6
    qa.push_back({1'b0, 12'hFFA});
    send(0, 8'd10); send(0, 8'hFD); send(0, 8'd7);
    check("basic_not_early", a.out_valid, 0);
    send(0, 8'hEC); drive(0, 1'b0, 8'd0);
    check("basic_latency", a.out_valid, 1);
    next_cycle();
    check("basic_idle", a.out_valid, 0);
    check("basic_acc_cleared", a.out_sum, 0);

    // backpressure with an extra product offered while holding
    a.out_ready = 1'b0;
    qa.push_back({1'b0, 12'hFFA});
    send(0, 8'd10); send(0, 8'hFD); send(0, 8'd7); send(0, 8'hEC);
    drive(0, 1'b1, 8'd50);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", a.out_valid, 1);
      check("bp_sum", a.out_sum, 12'hFFA);
      check("bp_in_ready", a.in_ready, 0);
    end
    next_cycle();
    drive(0, 1'b0, 8'd0);
    a.out_ready = 1'b1;
    next_cycle();
    check("bp_release_valid", a.out_valid, 0);
    check("bp_release_sum", a.out_sum, 0);

    // clear colliding with a transfer
    send(0, 8'd5); send(0, 8'd5);
    check("clr_partial", a.out_sum, 12'd10);
    a.clear = 1'b1; drive(0, 1'b1, 8'd9);
    @(negedge clk);
    check("clr_in_ready", a.in_ready, 0);
    next_cycle();
    a.clear = 1'b0; drive(0, 1'b0, 8'd0);
    check("clr_acc", a.out_sum, 0);
    check("clr_valid", a.out_valid, 0);
    qa.push_back({1'b0, 12'd10});
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3); send(0, 8'd4); drive(0, 1'b0, 8'd0);
    next_cycle();

    // clear while holding a result beats the output handshake
    a.out_ready = 1'b0;
    send(0, 8'd1); send(0, 8'd1); send(0, 8'd1); send(0, 8'd1); drive(0, 1'b0, 8'd0);
    a.clear = 1'b1; a.out_ready = 1'b1;
    next_cycle();
    a.clear = 1'b0;
    check("hold_clr_valid", a.out_valid, 0);
    check("hold_clr_sum", a.out_sum, 0);

    // gapped input
    qa.push_back({1'b0, 12'd400});
    for (int i = 0; i < 4; i++) begin
      send(0, 8'd100);
      if (i < 3) begin
        drive(0, 1'b0, 8'd0);
        next_cycle();
        check("gap_not_early", a.out_valid, 0);
      end
    end
    drive(0, 1'b0, 8'd0);
    check("gap_latency", a.out_valid, 1);
    next_cycle();

    // asynchronous reset mid-frame
    send(0, 8'd7); send(0, 8'd7); send(0, 8'd7); drive(0, 1'b0, 8'd0);
    #2;
    check("ar_partial", a.out_sum, 12'd21);
    rst_n = 1'b0;
    #1;
    check("ar_sum", a.out_sum, 0);
    check("ar_valid", a.out_valid, 0);
    check("ar_in_ready", a.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    qa.push_back({1'b0, 12'd8});
    send(0, 8'd2); send(0, 8'd2); send(0, 8'd2); send(0, 8'd2); drive(0, 1'b0, 8'd0);
    next_cycle();

    // LEN=20 saturation both ways, ovf cleared between frames
    qb.push_back({1'b1, 12'h800});
    repeat (20) send(1, 8'h80);
    drive(1, 1'b0, 8'd0);
    next_cycle();
    qb.push_back({1'b0, 12'd20});
    repeat (20) send(1, 8'd1);
    drive(1, 1'b0, 8'd0);
    next_cycle();
    qb.push_back({1'b1, 12'h7FF});
    repeat (20) send(1, 8'h7F);
    drive(1, 1'b0, 8'd0);
    next_cycle();

    // LEN=1: straight to HOLD, back-to-back frames
    qc.push_back({1'b0, 12'hFFB});
    qc.push_back({1'b0, 12'd3});
    send(2, 8'hFB);
    check("len1_latency", c.out_valid, 1);
    send(2, 8'd3); drive(2, 1'b0, 8'd0);
    check("len1_second", c.out_valid, 1);
    next_cycle();
    check("len1_idle", c.out_valid, 0);

    next_cycle();
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 8, meaning the signed product width from the Booth multiplier stage.
REQ-002 SHALL have parameter ACC_W, default 12, meaning the signed accumulator and result width; the design SHALL require ACC_W > PROD_W.
REQ-003 SHALL have parameter LEN, default 4, meaning the number of products per frame; the design SHALL require 1 <= LEN <= 255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_product holds a valid product.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-008 SHALL have port in_product, input, PROD_W bits: the signed two's-complement product.
REQ-009 SHALL have port clear, input, 1 bit: synchronous abort of the current frame.
REQ-010 SHALL have port out_valid, output, 1 bit: out_sum and out_ovf are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 SHALL have port out_sum, output, ACC_W bits: the signed frame sum.
REQ-013 SHALL have port out_ovf, output, 1 bit: sticky saturation flag for the frame.

Function
REQ-014 SHALL implement three states: IDLE (acc=0, cnt=0), ACCUM (0<cnt<LEN), HOLD (result presented).
REQ-015 SHALL drive in_ready = (state != HOLD) && !clear, combinationally.
REQ-016 SHALL transfer an input only on in_valid && in_ready, adding sign_extend(in_product) to acc and incrementing cnt.
REQ-017 SHALL compute each addition at ACC_W+1 bits; on a result above 2^(ACC_W-1)-1 or below -2^(ACC_W-1), acc SHALL saturate to that bound and the sticky ovf SHALL set.
REQ-018 SHALL move IDLE->ACCUM on the first accepted product when LEN>1, and SHALL move to HOLD on the LEN-th accepted product, including IDLE->HOLD directly when LEN=1.
REQ-019 SHALL assert out_valid in the cycle after the LEN-th product is accepted, a latency of 1 cycle; out_valid SHALL be registered.
REQ-020 SHALL hold out_sum and out_ovf stable while out_valid=1 && out_ready=0.
REQ-021 SHALL, on out_valid && out_ready, go to IDLE next cycle with out_valid=0, acc=0, cnt=0, ovf=0; a new product SHALL NOT be accepted in the handoff cycle.
REQ-022 SHALL drive out_sum = acc and out_ovf = ovf in every state; out_sum and out_ovf are meaningful only when out_valid=1.
REQ-023 SHALL, on clear=1 in any state, return to IDLE next cycle with acc, cnt and ovf zeroed and out_valid=0; clear SHALL take priority over an input transfer and over an output handshake in the same cycle, and the product or result SHALL be discarded.
REQ-024 SHALL never accept more than LEN products per frame; cnt SHALL NOT wrap.

Reset
REQ-025 SHALL, while rst_n=0 and independent of clk, force state=IDLE, acc=0, cnt=0, ovf=0 and out_valid=0.
REQ-026 SHALL, after rst_n=0, show out_sum=0, out_ovf=0 and in_ready=1 (with clear=0).
REQ-027 SHALL lose a partial frame entirely on reset mid-frame; the first frame after reset SHALL start with cnt=0.

Verification
REQ-028 Basic frame: LEN=4, products 10, -3, 7, -20 on consecutive cycles with out_ready=1 -> one cycle after the 4th, out_valid=1, out_sum=12'hFFA (-6), out_ovf=0; IDLE on the next cycle.
REQ-029 Backpressure: same frame with out_ready=0 for 5 cycles -> out_valid, out_sum=12'hFFA and in_ready=0 stable for all 5 cycles; an offered product is not consumed; release -> IDLE.
REQ-030 Saturation: LEN=20, twenty products of -128 (8'h80) -> out_sum=12'h800 (-2048), out_ovf=1; the next frame of 1,1,...,1 gives out_sum=20 with out_ovf=0.
REQ-031 Clear collision: LEN=4, two products of 5 accepted, then clear=1 together with in_valid=1 and product 9 -> in_ready=0, IDLE next cycle, acc=0; a following frame 1, 2, 3, 4 gives out_sum=10.
REQ-032 Async reset: rst_n dropped mid-cycle after 3 of 4 products -> out_valid=0 and acc=0 immediately, without waiting for a clk edge; after release, a frame 2, 2, 2, 2 gives out_sum=8.
REQ-033 Gapped input: LEN=4, in_valid toggled 1-0-1-0-... with products 100, 100, 100, 100 -> out_sum=400, out_ovf=0, out_valid one cycle after the 4th transfer.
